pkt_tx_serializer: RTL and testbench

- Consumes the packed outgoing packet fields from the reward stage on its done strobe.
- Converts them into a type-dependent byte stream (MEM_WIDTH=8) with an XOR checksum trailer.
- Hands the bytes to the radio TX buffer over a valid/ready handshake.
- Packet types that are never transmitted (CHE, invalid) are dropped with a flag.

---
 rtl/pkt_tx_serializer.sv | 193 +++++++++++++++++++
 tb/tb_pkt_tx_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_serializer.sv
// Packet TX serializer: turns the latched reward-stage fields into a typed byte
// stream with an XOR checksum trailer, handed out over a valid/ready handshake.
module pkt_tx_serializer #(
   parameter int WORD_WIDTH = 16,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  load,
   input  logic [2:0]            lPacketType,
   input  logic [WORD_WIDTH-1:0] lSourceID,
   input  logic [WORD_WIDTH-1:0] lSourceHops,
   input  logic [WORD_WIDTH-1:0] lQValue,
   input  logic [WORD_WIDTH-1:0] lEnergyLeft,
   input  logic [WORD_WIDTH-1:0] lDestinationID,
   input  logic [WORD_WIDTH-1:0] lChosenCH,
   input  logic [WORD_WIDTH-1:0] lHopsFromCH,
   output logic [BYTE_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  tx_last,
   output logic                  tx_done,
   output logic                  tx_drop,
   output logic                  overflow,
   output logic                  busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]            state;
   logic [3:0]            idx;
   logic [BYTE_WIDTH-1:0] csum;
   logic [2:0]            ptype;
   logic [WORD_WIDTH-1:0] src_id, src_hops, q_value, energy_left;
   logic [WORD_WIDTH-1:0] dest_id, chosen_ch, hops_from_ch;

   logic [3:0]            last_idx;
   logic [3:0]            body;
   logic [2:0]            slot;
   logic [WORD_WIDTH-1:0] cur_word;
   logic [BYTE_WIDTH-1:0] cur_byte;
   logic                  transmittable;

   assign transmittable = (lPacketType != 3'b001) && (lPacketType != 3'b111);

   // Byte 1 onwards carries fields two bytes each, so the field slot is (idx-1)/2
   // and an even (idx-1) selects the MSB byte.
   assign body = idx - 4'd1;
   assign slot = body[3:1];

   always_comb begin
      last_idx = 4'd15;
      case (ptype)
         3'b000:  last_idx = 4'd5;
         3'b010:  last_idx = 4'd7;
         3'b011:  last_idx = 4'd13;
         3'b100:  last_idx = 4'd7;
         default: last_idx = 4'd15;
      endcase
   end

   always_comb begin
      cur_word = '0;
      case (ptype)
         3'b000: begin
            case (slot)
               3'd0:    cur_word = src_id;
               3'd1:    cur_word = src_hops;
               default: cur_word = '0;
            endcase
         end
         3'b010: begin
            case (slot)
               3'd0:    cur_word = src_id;
               3'd1:    cur_word = q_value;
               3'd2:    cur_word = hops_from_ch;
               default: cur_word = '0;
            endcase
         end
         3'b011: begin
            case (slot)
               3'd0:    cur_word = src_id;
               3'd1:    cur_word = src_hops;
               3'd2:    cur_word = q_value;
               3'd3:    cur_word = energy_left;
               3'd4:    cur_word = dest_id;
               3'd5:    cur_word = hops_from_ch;
               default: cur_word = '0;
            endcase
         end
         3'b100: begin
            case (slot)
               3'd0:    cur_word = src_id;
               3'd1:    cur_word = q_value;
               3'd2:    cur_word = dest_id;
               default: cur_word = '0;
            endcase
         end
         default: begin
            case (slot)
               3'd0:    cur_word = src_id;
               3'd1:    cur_word = src_hops;
               3'd2:    cur_word = q_value;
               3'd3:    cur_word = energy_left;
               3'd4:    cur_word = hops_from_ch;
               3'd5:    cur_word = chosen_ch;
               3'd6:    cur_word = dest_id;
               default: cur_word = '0;
            endcase
         end
      endcase
   end

   always_comb begin
      cur_byte = cur_word[BYTE_WIDTH-1:0];
      if (idx == 4'd0)
         cur_byte = {{(BYTE_WIDTH-3){1'b0}}, ptype};
      else if (idx == last_idx)
         cur_byte = csum;
      else if (!body[0])
         cur_byte = cur_word[WORD_WIDTH-1 -: BYTE_WIDTH];
   end

   assign tx_valid = (state == ST_SEND);
   assign tx_data  = tx_valid ? cur_byte : '0;
   assign tx_last  = tx_valid && (idx == last_idx);
   assign tx_done  = (state == ST_DONE);
   assign busy     = (state != ST_IDLE);

   // Outputs are all derived from registered state, so a held-off byte stays put
   // until tx_ready lets it go.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state        <= ST_IDLE;
         idx          <= '0;
         csum         <= '0;
         ptype        <= '0;
         src_id       <= '0;
         src_hops     <= '0;
         q_value      <= '0;
         energy_left  <= '0;
         dest_id      <= '0;
         chosen_ch    <= '0;
         hops_from_ch <= '0;
         tx_drop      <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         tx_drop  <= 1'b0;
         overflow <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  if (transmittable) begin
                     ptype        <= lPacketType;
                     src_id       <= lSourceID;
                     src_hops     <= lSourceHops;
                     q_value      <= lQValue;
                     energy_left  <= lEnergyLeft;
                     dest_id      <= lDestinationID;
                     chosen_ch    <= lChosenCH;
                     hops_from_ch <= lHopsFromCH;
                     idx          <= '0;
                     csum         <= '0;
                     state        <= ST_SEND;
                  end else begin
                     tx_drop <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (load)
                  overflow <= 1'b1;
               if (tx_ready) begin
                  csum <= csum ^ cur_byte;
                  if (idx == last_idx)
                     state <= ST_DONE;
                  else
                     idx <= idx + 4'd1;
               end
            end
            ST_DONE: begin
               if (load)
                  overflow <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_tx_serializer.sv
// Directed self-checking bench for pkt_tx_serializer: per-type framing, stalls,
// drops, overflow and reset mid-frame.
module tb_pkt_tx_serializer;

   logic        clk = 1'b0;
   logic        nrst;
   logic        load;
   logic [2:0]  ptype;
   logic [15:0] src, hops, qv, en, dst, ch, hfc;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, tx_last, tx_done, tx_drop, overflow, busy;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_bytes [32];
   logic [7:0] got_bytes [32];
   int         exp_len;
   int         ovf_seen;
   int         n_got;
   logic       done_got;

   always #5 clk = ~clk;

   pkt_tx_serializer dut (
      .clk(clk), .nrst(nrst), .load(load), .lPacketType(ptype),
      .lSourceID(src), .lSourceHops(hops), .lQValue(qv), .lEnergyLeft(en),
      .lDestinationID(dst), .lChosenCH(ch), .lHopsFromCH(hfc),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
      .tx_done(tx_done), .tx_drop(tx_drop), .overflow(overflow), .busy(busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one packet on the load strobe for exactly one clock edge.
   task automatic applyStimulus(input logic [2:0] t, input logic [15:0] s, input logic [15:0] h,
                                input logic [15:0] q, input logic [15:0] e, input logic [15:0] d,
                                input logic [15:0] c, input logic [15:0] f);
      ptype = t; src = s; hops = h; qv = q; en = e; dst = d; ch = c; hfc = f;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   // Reference framing built from the bench's current field values.
   task automatic buildExpected();
      logic [15:0] w [7];
      int nw;
      logic [7:0] x;
      for (int i = 0; i < 7; i++) w[i] = '0;
      nw = 0;
      case (ptype)
         3'b000: begin w[0] = src; w[1] = hops; nw = 2; end
         3'b010: begin w[0] = src; w[1] = qv; w[2] = hfc; nw = 3; end
         3'b011: begin w[0] = src; w[1] = hops; w[2] = qv; w[3] = en; w[4] = dst; w[5] = hfc; nw = 6; end
         3'b100: begin w[0] = src; w[1] = qv; w[2] = dst; nw = 3; end
         default: begin w[0] = src; w[1] = hops; w[2] = qv; w[3] = en; w[4] = hfc; w[5] = ch; w[6] = dst; nw = 7; end
      endcase
      exp_bytes[0] = {5'b00000, ptype};
      for (int i = 0; i < nw; i++) begin
         exp_bytes[1 + 2*i] = w[i][15:8];
         exp_bytes[2 + 2*i] = w[i][7:0];
      end
      exp_len = 2*nw + 2;
      x = 8'h00;
      for (int i = 0; i < exp_len - 1; i++) x = x ^ exp_bytes[i];
      exp_bytes[exp_len - 1] = x;
   endtask

   // Drains one frame, checking each byte as it is offered; optional stall, an
   // injected second load, or an early abort after abort_at transfers.
   task automatic runFrame(input int stall_at, input int stall_len, input int ovf_at, input int abort_at);
      int stalls;
      logic injected;
      stalls = 0;
      injected = 1'b0;
      n_got = 0;
      done_got = 1'b0;
      ovf_seen = 0;
      for (int c = 0; c < 80 && !done_got && n_got != abort_at && n_got < 32; c++) begin
         if (overflow) ovf_seen++;
         if (tx_done) begin
            done_got = 1'b1;
            checkOutput("done_valid", {31'b0, tx_valid}, 32'd0);
            checkOutput("done_busy", {31'b0, busy}, 32'd1);
            load = 1'b0;
         end else begin
            if (ovf_at == n_got && !injected) begin
               injected = 1'b1;
               load = 1'b1; ptype = 3'b000; src = 16'hDEAD; hops = 16'hBEEF;
            end else begin
               load = 1'b0;
            end
            if (stall_at == n_got && stalls < stall_len) begin
               tx_ready = 1'b0;
               checkOutput("stall_valid", {31'b0, tx_valid}, 32'd1);
               checkOutput("stall_data", {24'b0, tx_data}, {24'b0, exp_bytes[n_got]});
               stalls++;
            end else begin
               tx_ready = 1'b1;
               checkOutput("valid", {31'b0, tx_valid}, 32'd1);
               checkOutput($sformatf("byte%0d", n_got), {24'b0, tx_data}, {24'b0, exp_bytes[n_got]});
               checkOutput($sformatf("last%0d", n_got), {31'b0, tx_last}, {31'b0, (n_got == exp_len - 1)});
               got_bytes[n_got] = tx_data;
               n_got++;
            end
         end
         tick();
      end
      load = 1'b0;
      tx_ready = 1'b1;
   endtask

   initial begin
      logic [7:0] x;
      int stray;
      nrst = 1'b0; load = 1'b0; tx_ready = 1'b1; ptype = '0;
      src = '0; hops = '0; qv = '0; en = '0; dst = '0; ch = '0; hfc = '0;
      for (int i = 0; i < 32; i++) begin exp_bytes[i] = '0; got_bytes[i] = '0; end
      #12;
      checkOutput("rst_valid", {31'b0, tx_valid}, 32'd0);
      checkOutput("rst_data", {24'b0, tx_data}, 32'd0);
      checkOutput("rst_flags", {27'b0, tx_last, tx_done, tx_drop, overflow, busy}, 32'd0);
      @(negedge clk) nrst = 1'b1;
      tick();

      // HB frame with hand-computed bytes
      applyStimulus(3'b000, 16'h0005, 16'h0002, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555);
      exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h05;
      exp_bytes[3] = 8'h00; exp_bytes[4] = 8'h02; exp_bytes[5] = 8'h07;
      exp_len = 6;
      runFrame(-1, 0, -1, -1);
      checkOutput("hb_done", {31'b0, done_got}, 32'd1);
      checkOutput("hb_count", n_got, 32'd6);
      checkOutput("hb_busy_after", {31'b0, busy}, 32'd0);

      // INV frame with hand-computed bytes
      applyStimulus(3'b010, 16'h0003, 16'h7777, 16'h00C8, 16'h8888, 16'h9999, 16'hAAAA, 16'h0002);
      exp_bytes[0] = 8'h02; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h03; exp_bytes[3] = 8'h00;
      exp_bytes[4] = 8'hC8; exp_bytes[5] = 8'h00; exp_bytes[6] = 8'h02; exp_bytes[7] = 8'hCB;
      exp_len = 8;
      runFrame(-1, 0, -1, -1);
      checkOutput("inv_done", {31'b0, done_got}, 32'd1);
      checkOutput("inv_count", n_got, 32'd8);

      // Data frame with a 3-cycle stall on byte index 2
      applyStimulus(3'b101, 16'h1234, 16'h0003, 16'h00FF, 16'h8000, 16'h00AA, 16'h0055, 16'h0001);
      buildExpected();
      runFrame(2, 3, -1, -1);
      checkOutput("data_done", {31'b0, done_got}, 32'd1);
      checkOutput("data_count", n_got, 32'd16);
      x = 8'h00;
      for (int i = 0; i < 15; i++) x = x ^ got_bytes[i];
      checkOutput("data_csum", {24'b0, got_bytes[15]}, {24'b0, x});

      // SOS frame, back-to-back style start right after IDLE
      applyStimulus(3'b110, 16'hA5A5, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C);
      buildExpected();
      runFrame(-1, 0, -1, -1);
      checkOutput("sos_count", n_got, 32'd16);

      // Non-transmittable types are dropped
      applyStimulus(3'b001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
      checkOutput("drop1_pulse", {31'b0, tx_drop}, 32'd1);
      checkOutput("drop1_idle", {30'b0, tx_valid, busy}, 32'd0);
      tick();
      checkOutput("drop1_once", {31'b0, tx_drop}, 32'd0);
      applyStimulus(3'b111, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
      checkOutput("drop7_pulse", {31'b0, tx_drop}, 32'd1);
      checkOutput("drop7_idle", {30'b0, tx_valid, busy}, 32'd0);
      tick();
      checkOutput("drop7_once", {31'b0, tx_drop}, 32'd0);

      // CHT frame with a second load during SEND
      applyStimulus(3'b100, 16'h0011, 16'h6666, 16'h0022, 16'h7777, 16'h0033, 16'h8888, 16'h9999);
      exp_bytes[0] = 8'h04; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h11; exp_bytes[3] = 8'h00;
      exp_bytes[4] = 8'h22; exp_bytes[5] = 8'h00; exp_bytes[6] = 8'h33; exp_bytes[7] = 8'h04;
      exp_len = 8;
      runFrame(-1, 0, 2, -1);
      checkOutput("cht_count", n_got, 32'd8);
      checkOutput("cht_overflow", ovf_seen, 32'd1);
      stray = 0;
      for (int i = 0; i < 6; i++) begin
         if (tx_valid || busy) stray++;
         tick();
      end
      checkOutput("cht_no_second", stray, 32'd0);

      // MR frame aborted by reset after 3 bytes
      applyStimulus(3'b011, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0000, 16'h0B0C);
      buildExpected();
      runFrame(-1, 0, -1, 3);
      checkOutput("abort_count", n_got, 32'd3);
      #2 nrst = 1'b0;
      #1;
      checkOutput("abort_valid", {31'b0, tx_valid}, 32'd0);
      checkOutput("abort_data", {24'b0, tx_data}, 32'd0);
      checkOutput("abort_flags", {27'b0, tx_last, tx_done, tx_drop, overflow, busy}, 32'd0);
      @(negedge clk) nrst = 1'b1;
      tick();
      checkOutput("abort_no_done", {31'b0, tx_done}, 32'd0);

      // Fresh MR frame after reset must carry a clean checksum
      applyStimulus(3'b011, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0000, 16'h0B0C);
      buildExpected();
      runFrame(-1, 0, -1, -1);
      checkOutput("mr_done", {31'b0, done_got}, 32'd1);
      checkOutput("mr_count", n_got, 32'd14);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
